// File: rtl/io_flash_ctrl.sv
// Off-chip parallel I/O sequencer and instruction-ROM flash loader for the HMMM core.
// Optional macro FLASH_CHECKSUM_EN adds a running 16-bit sum of flashed words on flashChecksum.
module io_flash_ctrl #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ADDR_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inputReady,
    input  logic [15:0]       parallelIn,
    input  logic              flashEnable,
    input  logic              readReq,
    input  logic              writeReq,
    input  logic [15:0]       writeData,
    output logic              inputWaiting,
    output logic [15:0]       parallelOut,
    output logic [15:0]       readData,
    output logic              readDone,
    output logic              IObusy,
    output logic              coreHold,
    output logic              pcReset,
    output logic              romWe,
    output logic [ADDR_W-1:0] romWaddr,
    output logic [15:0]       romWdata,
    output logic [15:0]       flashChecksum
);
    localparam int unsigned DATA_W = 16;
    localparam logic [ADDR_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        IDLE,
        READ_WAIT,
        READ_DONE,
        FLASH_WAIT,
        FLASH_WRITE,
        FLASH_FULL,
        FLASH_EXIT
    } state_t;

    state_t state, state_d;

    logic [SYNC_STAGES-1:0] rdy_sync;
    logic [SYNC_STAGES-1:0] fl_sync;
    logic                   rdy_prev;
    logic                   rdy_s;
    logic                   fl_s;
    logic                   rdy_edge;

    logic [ADDR_W-1:0] cnt, cnt_d;
    logic [DATA_W-1:0] parallel_out_d;
    logic [DATA_W-1:0] read_data_d;
    logic [ADDR_W-1:0] rom_waddr_d;
    logic [DATA_W-1:0] rom_wdata_d;
    logic              waiting_d;
    logic              busy_d;
    logic              done_d;
    logic              hold_d;
    logic              pc_reset_d;
    logic              rom_we_d;

    assign rdy_s    = rdy_sync[SYNC_STAGES-1];
    assign fl_s     = fl_sync[SYNC_STAGES-1];
    assign rdy_edge = rdy_s & ~rdy_prev;

    // Synchronizers for the asynchronous strobe and flash request pins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdy_sync <= '0;
            fl_sync  <= '0;
            rdy_prev <= 1'b0;
        end else begin
            rdy_sync <= {rdy_sync[SYNC_STAGES-2:0], inputReady};
            fl_sync  <= {fl_sync[SYNC_STAGES-2:0], flashEnable};
            rdy_prev <= rdy_s;
        end
    end

    // Next state, datapath updates, and outputs decoded from the next state
    always_comb begin
        state_d        = state;
        cnt_d          = cnt;
        parallel_out_d = parallelOut;
        read_data_d    = readData;
        rom_waddr_d    = romWaddr;
        rom_wdata_d    = romWdata;

        case (state)
            IDLE: begin
                if (fl_s) begin
                    state_d = FLASH_WAIT;
                    cnt_d   = '0;
                end else if (readReq) begin
                    state_d = READ_WAIT;
                end else if (writeReq) begin
                    parallel_out_d = writeData;
                end
            end
            READ_WAIT: begin
                if (fl_s) begin
                    state_d = FLASH_WAIT;
                    cnt_d   = '0;
                end else if (rdy_edge) begin
                    read_data_d = parallelIn;
                    state_d     = READ_DONE;
                end
            end
            READ_DONE: state_d = IDLE;
            FLASH_WAIT: begin
                if (!fl_s) begin
                    state_d = FLASH_EXIT;
                end else if (rdy_edge) begin
                    rom_wdata_d = parallelIn;
                    rom_waddr_d = cnt;
                    state_d     = FLASH_WRITE;
                end
            end
            // Write always completes; a flashEnable drop is seen back in FLASH_WAIT
            FLASH_WRITE: begin
                cnt_d   = cnt + ADDR_W'(1);
                state_d = (cnt == CNT_MAX) ? FLASH_FULL : FLASH_WAIT;
            end
            FLASH_FULL: begin
                if (!fl_s) state_d = FLASH_EXIT;
            end
            FLASH_EXIT: state_d = IDLE;
            default:    state_d = IDLE;
        endcase

        waiting_d  = (state_d == READ_WAIT) || (state_d == FLASH_WAIT);
        busy_d     = (state_d == READ_WAIT);
        done_d     = (state_d == READ_DONE);
        hold_d     = (state_d == FLASH_WAIT) || (state_d == FLASH_WRITE) ||
                     (state_d == FLASH_FULL) || (state_d == FLASH_EXIT);
        pc_reset_d = (state_d == FLASH_EXIT);
        rom_we_d   = (state_d == FLASH_WRITE);
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            inputWaiting <= 1'b0;
            parallelOut  <= '0;
            readData     <= '0;
            readDone     <= 1'b0;
            IObusy       <= 1'b0;
            coreHold     <= 1'b0;
            pcReset      <= 1'b0;
            romWe        <= 1'b0;
            romWaddr     <= '0;
            romWdata     <= '0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            inputWaiting <= waiting_d;
            parallelOut  <= parallel_out_d;
            readData     <= read_data_d;
            readDone     <= done_d;
            IObusy       <= busy_d;
            coreHold     <= hold_d;
            pcReset      <= pc_reset_d;
            romWe        <= rom_we_d;
            romWaddr     <= rom_waddr_d;
            romWdata     <= rom_wdata_d;
        end
    end

`ifdef FLASH_CHECKSUM_EN
    logic [DATA_W-1:0] csum;
    logic              flash_start;

    assign flash_start = (state_d == FLASH_WAIT) && ((state == IDLE) || (state == READ_WAIT));

    // Accumulator restarts with each new flash and holds after exit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum <= '0;
        end else if (flash_start) begin
            csum <= '0;
        end else if (state == FLASH_WRITE) begin
            csum <= csum + romWdata;
        end
    end

    assign flashChecksum = csum;
`else
    assign flashChecksum = '0;
`endif

endmodule
